prewish_pattern_sequencer: RTL and testbench
============================================

Name: prewish_pattern_sequencer

Overview:
- Parametrised pattern source that generates timed mask updates for the mentor/blinky chain.
- Holds a loadable table of 2**DEPTH_BITS patterns, each DAT_WIDTH wide, and an interval timer.
- Each time the interval expires, it presents the next table entry with a Wishbone-style STB_O/ACK_I handshake.
- Next entry is chosen by run-time mode: sequential, ping-pong, pseudo-random or hold. Replaces hardcoded newmask logic with a reusable block.

Parameters:
- DAT_WIDTH, 8, pattern width in bits.
- DEPTH_BITS, 3, table index width; DEPTH = 2**DEPTH_BITS entries.
- INTERVAL_BITS, 26, width of the interval timer and INTERVAL_I.
- ACK_TIMEOUT, 15, cycles STB_O may stay high without ACK_I; 0 disables the timeout.

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  synchronous reset, active-high.
- EN_I  in  1  run enable.
- MODE_I  in  2  00 sequential, 01 ping-pong, 10 pseudo-random, 11 hold.
- INTERVAL_I  in  INTERVAL_BITS  cycles between strobes; 0 is treated as 1.
- LD_STB_I  in  1  table write strobe.
- LD_ADR_I  in  DEPTH_BITS  table write address.
- LD_DAT_I  in  DAT_WIDTH  table write data.
- STB_O  out  1  pattern valid strobe to mentor.
- DAT_O  out  DAT_WIDTH  pattern data.
- ACK_I  in  1  downstream acknowledge.
- IDX_O  out  DEPTH_BITS  index of the last/current presented entry.
- ERR_O  out  1  sticky ack-timeout flag.

Behaviour:
- Reset (RST_I high at a CLK_I edge; dominates all other inputs):
  - STB_O=0, DAT_O=0, IDX_O=0, ERR_O=0.
  - State=IDLE, timer=0, ping-pong direction=up, LFSR=16'hACE1.
  - Table entry i loads a thermometer value: top min(i+1,DAT_WIDTH) bits set, rest 0.
- Table write:
  - Takes effect on any cycle LD_STB_I=1 (not during reset): table[LD_ADR_I] <= LD_DAT_I.
  - Allowed in any state.
  - DAT_O is latched at strobe entry, so writes never disturb a strobe in progress.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Free-runs every non-reset cycle.
- IDLE: if EN_I=1, load timer=max(INTERVAL_I,1) and go to WAIT.
- WAIT:
  - If EN_I=1, timer decrements; if EN_I=0, timer freezes, no other change.
  - When timer is 1 and decrements, go to STROBE next cycle: STB_O=1, DAT_O=table[idx], IDX_O=idx.
  - Net latency: STB_O rises exactly max(INTERVAL_I,1) enabled cycles after WAIT entry.
  - INTERVAL_I is sampled only at timer load.
- STROBE:
  - STB_O and DAT_O are held stable.
  - ACK_I sampled high → next cycle STB_O=0 and go to ADVANCE. An ACK_I arriving in the same cycle STB_O rises counts.
  - ACK_I is ignored outside STROBE.
  - If ACK_TIMEOUT>0 and STB_O has been high ACK_TIMEOUT cycles without ack → STB_O=0, ERR_O=1 (sticky until reset), go to ADVANCE.
  - EN_I=0 does not abort a strobe.
- ADVANCE (one cycle; MODE_I sampled only here):
  - 00: idx+1, wrapping DEPTH-1→0.
  - 01: step by direction. At DEPTH-1 going up, reverse and go to DEPTH-2. At 0 going down, reverse and go to 1. If DEPTH=2, toggle between 0 and 1.
  - 10: idx=LFSR[DEPTH_BITS-1:0]; if equal to current idx, use idx+1 (wrap), so no immediate repeat.
  - 11: idx unchanged; the same entry is re-strobed.
  - Then: if EN_I=1, reload timer and go to WAIT; else go to IDLE.
- DAT_O holds the last pattern after STB_O falls. IDX_O updates only at strobe entry.

Optional Feature:
- Macro: PREWISH_SEQ_FIRST_IMMEDIATE_EN.
- Defined: IDLE with EN_I=1 goes straight to STROBE with table[0] on the next cycle, but only for the first strobe after reset. Later IDLE exits go through WAIT as normal.
- Undefined: the first strobe waits a full interval, like every other strobe.

Test Plan:
- Reset default, macro off:
  - Stimulus: INTERVAL_I=4, MODE_I=00, EN_I=1, ACK_I tied high, reset released at cycle 0.
  - Required: STB_O high exactly at cycles 5, 11, 17 with DAT_O=8'h80, 8'hC0, 8'hE0, and IDX_O=0, 1, 2.
- Ping-pong, DEPTH_BITS=2: successive IDX_O = 0,1,2,3,2,1,0,1.
- Timeout:
  - Stimulus: ACK_I=0, ACK_TIMEOUT=15.
  - Required: STB_O high 15 cycles, then low; ERR_O=1 and stays 1 through later acked strobes until RST_I.
- Table write during strobe:
  - Stimulus: hold ACK_I low, write table[idx]=8'h55 mid-strobe.
  - Required: DAT_O unchanged during that strobe; 8'h55 appears when that index is next strobed.
- Random and hold:
  - MODE_I=10 over 64 strobes: no two consecutive IDX_O equal.
  - MODE_I=11: IDX_O is constant.
- Disable/reset mid-operation:
  - EN_I=0 during WAIT freezes the timer; re-enable resumes the countdown.
  - EN_I=0 during STROBE completes the ack, then goes to IDLE.
  - RST_I pulsed while STB_O=1: STB_O=0 the next cycle and the table returns to thermometer defaults.

Source files
------------

// File: rtl/prewish_pattern_sequencer.sv
`default_nettype none
// =============================================================================
// Module  : prewish_pattern_sequencer
// Brief   : Timed pattern source (table + interval timer) with STB/ACK handshake.
//           Macro PREWISH_SEQ_FIRST_IMMEDIATE_EN: first strobe after reset skips the wait.
// Revision: 1.0
// =============================================================================
module prewish_pattern_sequencer #(
  parameter int DAT_WIDTH     = 8,
  parameter int DEPTH_BITS    = 3,
  parameter int INTERVAL_BITS = 26,
  parameter int ACK_TIMEOUT   = 15
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     EN_I,
  input  logic [1:0]               MODE_I,
  input  logic [INTERVAL_BITS-1:0] INTERVAL_I,
  input  logic                     LD_STB_I,
  input  logic [DEPTH_BITS-1:0]    LD_ADR_I,
  input  logic [DAT_WIDTH-1:0]     LD_DAT_I,
  output logic                     STB_O,
  output logic [DAT_WIDTH-1:0]     DAT_O,
  input  logic                     ACK_I,
  output logic [DEPTH_BITS-1:0]    IDX_O,
  output logic                     ERR_O
);

  localparam int DEPTH = 2**DEPTH_BITS;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_STROBE  = 2'd2;
  localparam logic [1:0] S_ADVANCE = 2'd3;

  localparam logic [DEPTH_BITS-1:0]    IDX_ONE   = DEPTH_BITS'(1);
  localparam logic [DEPTH_BITS-1:0]    IDX_LAST  = {DEPTH_BITS{1'b1}};
  localparam logic [INTERVAL_BITS-1:0] TIMER_ONE = INTERVAL_BITS'(1);

  logic [1:0]               state, state_next;
  logic [INTERVAL_BITS-1:0] timer;
  logic [INTERVAL_BITS-1:0] interval_eff;
  logic [DAT_WIDTH-1:0]     pat_table [DEPTH];
  logic [DEPTH_BITS-1:0]    idx, idx_next, rnd_idx;
  logic                     dir_up, dir_up_next;
  logic [15:0]              lfsr;
  logic                     load_timer, strobe_entry, timeout_hit;

  function automatic logic [DAT_WIDTH-1:0] therm(input int i);
    logic [DAT_WIDTH-1:0] v;
    v = '0;
    for (int b = 0; b < DAT_WIDTH; b++) begin
      if (b <= i) v[DAT_WIDTH-1-b] = 1'b1;
    end
    return v;
  endfunction

  assign interval_eff = (INTERVAL_I == '0) ? TIMER_ONE : INTERVAL_I;
  assign rnd_idx      = lfsr[DEPTH_BITS-1:0];
  assign load_timer   = (state_next == S_WAIT)   && (state != S_WAIT);
  assign strobe_entry = (state_next == S_STROBE) && (state != S_STROBE);

`ifdef PREWISH_SEQ_FIRST_IMMEDIATE_EN
  logic first_done;
  always_ff @(posedge CLK_I) begin
    if (RST_I)             first_done <= 1'b0;
    else if (strobe_entry) first_done <= 1'b1;
  end
`endif

  generate
    if (ACK_TIMEOUT > 0) begin : g_timeout
      localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
      logic [TO_W-1:0] to_cnt;
      // Counts strobe cycles already elapsed; cleared whenever not strobing.
      always_ff @(posedge CLK_I) begin
        if (RST_I || state != S_STROBE) to_cnt <= '0;
        else                            to_cnt <= to_cnt + TO_W'(1);
      end
      assign timeout_hit = (state == S_STROBE) && (to_cnt == TO_W'(ACK_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (EN_I) begin
`ifdef PREWISH_SEQ_FIRST_IMMEDIATE_EN
          state_next = first_done ? S_WAIT : S_STROBE;
`else
          state_next = S_WAIT;
`endif
        end
      end
      S_WAIT:    if (EN_I && timer == TIMER_ONE) state_next = S_STROBE;
      S_STROBE:  if (ACK_I || timeout_hit)       state_next = S_ADVANCE;
      S_ADVANCE: state_next = EN_I ? S_WAIT : S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    STB_O = (state == S_STROBE);
  end

  always_comb begin
    idx_next    = idx;
    dir_up_next = dir_up;
    case (MODE_I)
      2'b00: idx_next = idx + IDX_ONE;
      2'b01: begin
        if (dir_up) begin
          if (idx == IDX_LAST) begin
            idx_next    = IDX_LAST - IDX_ONE;
            dir_up_next = 1'b0;
          end else begin
            idx_next = idx + IDX_ONE;
          end
        end else begin
          if (idx == '0) begin
            idx_next    = IDX_ONE;
            dir_up_next = 1'b1;
          end else begin
            idx_next = idx - IDX_ONE;
          end
        end
      end
      2'b10:   idx_next = (rnd_idx == idx) ? idx + IDX_ONE : rnd_idx;
      default: idx_next = idx;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      timer  <= '0;
      idx    <= '0;
      dir_up <= 1'b1;
      lfsr   <= 16'hACE1;
      DAT_O  <= '0;
      IDX_O  <= '0;
      ERR_O  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) pat_table[i] <= therm(i);
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (LD_STB_I) pat_table[LD_ADR_I] <= LD_DAT_I;
      if (load_timer)                   timer <= interval_eff;
      else if (state == S_WAIT && EN_I) timer <= timer - TIMER_ONE;
      // Pattern is captured here so later table writes cannot disturb the strobe.
      if (strobe_entry) begin
        DAT_O <= pat_table[idx];
        IDX_O <= idx;
      end
      if (state == S_STROBE && !ACK_I && timeout_hit) ERR_O <= 1'b1;
      if (state == S_ADVANCE) begin
        idx    <= idx_next;
        dir_up <= dir_up_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prewish_pattern_sequencer.sv
`default_nettype none
// Bench for prewish_pattern_sequencer: directed and random stimulus against a
// transaction-level model of the pattern sequencer.
module tb_prewish_pattern_sequencer;

  localparam int DW = 8, DB = 3, IB = 26, TO = 15, DEPTH = 8;
`ifdef PREWISH_SEQ_FIRST_IMMEDIATE_EN
  localparam bit FIRST_IMM = 1'b1;
`else
  localparam bit FIRST_IMM = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1, en = 1'b0, ack = 1'b0, ld_stb = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [IB-1:0] interval = IB'(1);
  logic [DB-1:0] ld_adr = '0;
  logic [DW-1:0] ld_dat = '0;
  logic          stb, err;
  logic [DW-1:0] dat;
  logic [DB-1:0] idx_o;

  prewish_pattern_sequencer #(
    .DAT_WIDTH(DW), .DEPTH_BITS(DB), .INTERVAL_BITS(IB), .ACK_TIMEOUT(TO)
  ) dut (
    .CLK_I(clk), .RST_I(rst), .EN_I(en), .MODE_I(mode), .INTERVAL_I(interval),
    .LD_STB_I(ld_stb), .LD_ADR_I(ld_adr), .LD_DAT_I(ld_dat),
    .STB_O(stb), .DAT_O(dat), .ACK_I(ack), .IDX_O(idx_o), .ERR_O(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, base = 0;

  typedef struct { int c; int d; int i; } srec_t;
  srec_t strobes[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 counting down, 2 presenting, 3 stepping.
  logic [DW-1:0] m_tab [DEPTH];
  logic [15:0]   m_lfsr;
  int            m_idx, m_phase, m_left, m_age, m_dat, m_idxo;
  bit            m_up, m_stb, m_err, m_first;

  task automatic present();
    m_phase = 2; m_age = 0; m_dat = int'(m_tab[m_idx]); m_idxo = m_idx; m_first = 1'b1;
  endtask

  task automatic advance(input int md);
    int nxt;
    case (md)
      0: m_idx = (m_idx + 1) % DEPTH;
      1: begin
        if (m_up) begin
          if (m_idx == DEPTH - 1) begin m_up = 1'b0; m_idx = DEPTH - 2; end
          else m_idx = m_idx + 1;
        end else begin
          if (m_idx == 0) begin m_up = 1'b1; m_idx = 1; end
          else m_idx = m_idx - 1;
        end
      end
      2: begin
        nxt = int'(m_lfsr) % DEPTH;
        if (nxt == m_idx) nxt = (nxt + 1) % DEPTH;
        m_idx = nxt;
      end
      default: ;
    endcase
  endtask

  task automatic model_step(input bit r, input bit e, input int md, input int iv,
                            input bit ls, input int la, input logic [DW-1:0] ld, input bit a);
    logic [DW-1:0] ones;
    ones = '1;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) m_tab[i] = ones << (DW - 1 - i);
      m_idx = 0; m_up = 1'b1; m_lfsr = 16'hACE1; m_phase = 0; m_left = 0; m_age = 0;
      m_stb = 1'b0; m_dat = 0; m_idxo = 0; m_err = 1'b0; m_first = 1'b0;
      return;
    end
    case (m_phase)
      0: if (e) begin
           if (FIRST_IMM && !m_first) present();
           else begin m_phase = 1; m_left = (iv == 0) ? 1 : iv; end
         end
      1: if (e) begin
           m_left--;
           if (m_left == 0) present();
         end
      2: begin
           m_age++;
           if (a) m_phase = 3;
           else if (TO > 0 && m_age == TO) begin m_err = 1'b1; m_phase = 3; end
         end
      default: begin
           advance(md);
           if (e) begin m_phase = 1; m_left = (iv == 0) ? 1 : iv; end
           else m_phase = 0;
         end
    endcase
    if (ls) m_tab[la] = ld;
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    m_stb  = (m_phase == 2);
  endtask

  // Compare process: model advances on each edge, DUT sampled 1 time unit later.
  initial begin
    bit prev_stb;
    prev_stb = 1'b0;
    forever begin
      @(posedge clk);
      model_step(rst, en, int'(mode), int'(interval), ld_stb, int'(ld_adr), ld_dat, ack);
      cyc++;
      #1;
      check("stb", int'(stb),   int'(m_stb));
      check("dat", int'(dat),   m_dat);
      check("idx", int'(idx_o), m_idxo);
      check("err", int'(err),   int'(m_err));
      if (stb && !prev_stb) strobes.push_back('{cyc - base, int'(dat), int'(idx_o)});
      prev_stb = stb;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ld_stb = 1'b0;
    tick(2);
    rst = 1'b0; base = cyc; strobes.delete();
  endtask

  task automatic wait_strobes(input int n, input int budget, input string name);
    int t;
    t = 0;
    while (strobes.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, int'(strobes.size() >= n), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end expected end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] a_dat [3];
    int pp [16];
    logic [DW-1:0] th [8];
    int len, reps, ack_pct;
    a_dat = '{8'h80, 8'hC0, 8'hE0};
    pp    = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    th    = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

    // Basic timing: interval 4, sequential, ack tied high
    mode = 2'd0; interval = IB'(4); en = 1'b1; ack = 1'b1;
    do_reset();
    check("rst_stb", int'(stb), 0);
    check("rst_dat", int'(dat), 0);
    wait_strobes(3, 100, "A_wait");
    for (int k = 0; k < 3; k++) begin
      if (strobes.size() > k) begin
        check("A_cyc", strobes[k].c, (FIRST_IMM ? 1 : 5) + 6 * k);
        check("A_dat", strobes[k].d, int'(a_dat[k]));
        check("A_idx", strobes[k].i, k);
      end
    end

    // Ping-pong
    mode = 2'd1; interval = IB'(1);
    do_reset();
    wait_strobes(16, 300, "B_wait");
    for (int k = 0; k < 16; k++)
      if (strobes.size() > k) check("B_pingpong_idx", strobes[k].i, pp[k]);

    // Ack timeout and sticky error
    mode = 2'd0; interval = IB'(2); ack = 1'b0;
    do_reset();
    wait_strobes(1, 50, "C_wait");
    len = 0;
    while (stb && len < 40) begin len++; @(negedge clk); end
    check("C_stb_len", len, 15);
    check("C_err_set", int'(err), 1);
    ack = 1'b1;
    wait_strobes(4, 100, "C_wait2");
    check("C_err_sticky", int'(err), 1);
    do_reset();
    check("C_err_reset", int'(err), 0);

    // Table write during a strobe, then hold mode
    ack = 1'b0;
    do_reset();
    wait_strobes(1, 50, "D_wait");
    ld_stb = 1'b1; ld_adr = '0; ld_dat = 8'h55;
    tick(1);
    ld_stb = 1'b0;
    tick(2);
    check("D_dat_stable", int'(dat), 8'h80);
    mode = 2'd3; ack = 1'b1;
    wait_strobes(7, 100, "D_wait2");
    if (strobes.size() > 1) check("D_new_dat", strobes[1].d, 8'h55);
    for (int k = 1; k < 7; k++)
      if (strobes.size() > k) check("D_hold_idx", strobes[k].i, 0);

    // Pseudo-random: no immediate repeat over 64 strobes
    mode = 2'd2; interval = IB'(1);
    do_reset();
    wait_strobes(64, 600, "E_wait");
    reps = 0;
    for (int k = 1; k < 64; k++)
      if (strobes.size() > k && strobes[k].i == strobes[k-1].i) reps++;
    check("E_no_repeat", reps, 0);

    // Enable freeze during WAIT, with random table writes
    mode = 2'd0; interval = IB'(6);
    do_reset();
    tick(3);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ld_stb = 1'b1; ld_adr = DB'($urandom_range(1, 7)); ld_dat = DW'($urandom);
      tick(1);
    end
    ld_stb = 1'b0; en = 1'b1;
    wait_strobes(1, 50, "F_wait");
    if (strobes.size() > 0) check("F_freeze_cyc", strobes[0].c, FIRST_IMM ? 1 : 12);

    // Disable during a strobe: ack completes, then idle
    ack = 1'b0;
    wait_strobes(2, 60, "F_wait2");
    en = 1'b0;
    tick(3);
    ack = 1'b1;
    tick(20);
    check("F_idle_count", strobes.size(), 2);
    check("F_idle_stb", int'(stb), 0);

    // Reset while strobing restores thermometer table
    en = 1'b1; ack = 1'b0; interval = IB'(2);
    wait_strobes(3, 60, "R_wait");
    rst = 1'b1;
    tick(1);
    check("R_stb", int'(stb), 0);
    check("R_idx", int'(idx_o), 0);
    rst = 1'b0; base = cyc; strobes.delete();
    ack = 1'b1; interval = IB'(1);
    wait_strobes(8, 100, "R_wait2");
    for (int k = 0; k < 8; k++)
      if (strobes.size() > k) check("R_therm", strobes[k].d, int'(th[k]));

    // Fully random traffic
    ack_pct = 90;
    for (int c = 0; c < 2000; c++) begin
      if (c % 400 == 0) ack_pct = (c % 800 == 0) ? 90 : 3;
      rst    = ($urandom_range(0, 299) == 0);
      en     = ($urandom_range(0, 9) != 0);
      mode   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) interval = IB'($urandom_range(0, 4));
      ack    = ($urandom_range(0, 99) < ack_pct);
      ld_stb = ($urandom_range(0, 15) == 0);
      ld_adr = DB'($urandom_range(0, 7));
      ld_dat = DW'($urandom);
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
